// File: rtl/mmu_pkg.sv
// rtl/mmu_pkg.sv - shared state type, PTE bit indices and line helpers for the PTE memory responder
package mmu_pkg;

  localparam int PTE_V     = 0;
  localparam int PTE_A     = 6;
  localparam int PTE_D     = 7;
  localparam int L2_LINE_W = 128;

  typedef enum logic [3:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    RD_RSP,
    MK_RD_REQ,
    MK_RD_WAIT,
    MK_MOD,
    MK_WR_REQ,
    MK_WR_WAIT,
    MK_RSP
  } resp_state_t;

  // Pick the 64-bit PTE out of a 16B line; sel is address bit 3
  function automatic logic [63:0] pte_half(input logic [L2_LINE_W-1:0] line, input logic sel);
    return sel ? line[127:64] : line[63:0];
  endfunction

  // Replace the 64-bit PTE half of a 16B line selected by address bit 3
  function automatic logic [L2_LINE_W-1:0] pte_merge(input logic [L2_LINE_W-1:0] line,
                                                     input logic sel, input logic [63:0] pte);
    return sel ? {pte, line[63:0]} : {line[127:64], pte};
  endfunction

endpackage

// File: rtl/pte_line_buf.sv
// rtl/pte_line_buf.sv - one-entry 16B line buffer (tag, valid, data) with fill and lookup
module pte_line_buf
  import mmu_pkg::*;
#(
  parameter int TAG_W = 28
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fill_en,
  input  logic [TAG_W-1:0]     fill_tag,
  input  logic [L2_LINE_W-1:0] fill_data,
  input  logic [TAG_W-1:0]     lookup_tag,
  output logic                 hit,
  output logic [L2_LINE_W-1:0] hit_data
);

  logic                 buf_valid;
  logic [TAG_W-1:0]     buf_tag;
  logic [L2_LINE_W-1:0] buf_data;

  // Fills and mark write-backs both overwrite the single entry; reset invalidates it
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
    end else if (fill_en) begin
      buf_valid <= 1'b1;
      buf_tag   <= fill_tag;
      buf_data  <= fill_data;
    end
  end

  assign hit      = buf_valid && (buf_tag == lookup_tag);
  assign hit_data = buf_data;

endmodule

// File: rtl/pte_mem_responder.sv
// rtl/pte_mem_responder.sv - PTE read / A-D mark responder on the L2 port; optional line buffer via PTE_RSP_LINEBUF_EN
module pte_mem_responder
  import mmu_pkg::*;
#(
  parameter int PA_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 walk_req_valid,
  input  logic [PA_W-1:0]      walk_req_addr,
  output logic                 walk_rsp_valid,
  output logic [63:0]          walk_rsp_data,
  output logic [L2_LINE_W-1:0] walk_rsp_cacheline,
  input  logic                 mark_valid,
  input  logic                 mark_accessed,
  input  logic                 mark_dirty,
  input  logic [63:0]          mark_addr,
  output logic                 mark_rsp_valid,
  output logic                 l2_req_valid,
  input  logic                 l2_req_ready,
  output logic [PA_W-1:0]      l2_req_addr,
  output logic                 l2_req_store,
  output logic [L2_LINE_W-1:0] l2_req_data,
  input  logic                 l2_rsp_valid,
  input  logic [L2_LINE_W-1:0] l2_rsp_data
);

  resp_state_t          state;
  logic                 rd_pend, mk_pend, mk_a, mk_d;
  logic [PA_W-1:3]      rd_addr, mk_addr;
  logic [L2_LINE_W-1:0] line;
  logic [63:0]          mk_old, mk_new;
  logic [L2_LINE_W-1:0] mk_line;
  logic                 lb_hit, rd_done, mk_done;
  logic                 unused_ok;

  assign unused_ok = ^{walk_req_addr[2:0], mark_addr[63:PA_W], mark_addr[2:0]};

  // Dirty implies accessed, so A is forced whenever D is requested
  assign mk_old  = pte_half(line, mk_addr[3]);
  assign mk_new  = mk_old | ({63'b0, mk_a | mk_d} << PTE_A) | ({63'b0, mk_d} << PTE_D);
  assign mk_line = pte_merge(line, mk_addr[3], mk_new);

  // Pending entries stay set until their response is issued, which is when a new one may land
  assign rd_done = (state == RD_RSP) || (state == IDLE && !mk_pend && rd_pend && lb_hit);
  assign mk_done = (state == MK_RSP) || (state == IDLE && mk_pend && !(mk_a || mk_d));

`ifdef PTE_RSP_LINEBUF_EN
  logic                 lb_fill;
  logic [PA_W-5:0]      lb_fill_tag;
  logic [L2_LINE_W-1:0] lb_fill_data, lb_data;

  assign lb_fill      = (l2_rsp_valid && (state == RD_WAIT || state == MK_RD_WAIT)) ||
                        (state == MK_MOD && mk_new != mk_old);
  assign lb_fill_tag  = (state == RD_WAIT) ? rd_addr[PA_W-1:4] : mk_addr[PA_W-1:4];
  assign lb_fill_data = (state == MK_MOD) ? mk_line : l2_rsp_data;

  pte_line_buf #(.TAG_W(PA_W-4)) u_line_buf (
    .clk        (clk),
    .reset      (reset),
    .fill_en    (lb_fill),
    .fill_tag   (lb_fill_tag),
    .fill_data  (lb_fill_data),
    .lookup_tag (rd_addr[PA_W-1:4]),
    .hit        (lb_hit),
    .hit_data   (lb_data)
  );
`else
  assign lb_hit = 1'b0;
`endif

  // Request capture plus the L2 transaction FSM; all outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      rd_pend            <= 1'b0;
      mk_pend            <= 1'b0;
      mk_a               <= 1'b0;
      mk_d               <= 1'b0;
      rd_addr            <= '0;
      mk_addr            <= '0;
      line               <= '0;
      walk_rsp_valid     <= 1'b0;
      walk_rsp_data      <= '0;
      walk_rsp_cacheline <= '0;
      mark_rsp_valid     <= 1'b0;
      l2_req_valid       <= 1'b0;
      l2_req_addr        <= '0;
      l2_req_store       <= 1'b0;
      l2_req_data        <= '0;
    end else begin
      walk_rsp_valid <= 1'b0;
      mark_rsp_valid <= 1'b0;
      if (rd_done) rd_pend <= 1'b0;
      if (mk_done) mk_pend <= 1'b0;

      case (state)
        IDLE: begin
          if (mk_pend) begin
            if (mk_a || mk_d) begin
              state        <= MK_RD_REQ;
              l2_req_valid <= 1'b1;
              l2_req_addr  <= {mk_addr[PA_W-1:4], 4'b0};
              l2_req_store <= 1'b0;
              l2_req_data  <= '0;
            end else begin
              mark_rsp_valid <= 1'b1;
            end
          end else if (rd_pend) begin
`ifdef PTE_RSP_LINEBUF_EN
            if (lb_hit) begin
              walk_rsp_valid     <= 1'b1;
              walk_rsp_data      <= pte_half(lb_data, rd_addr[3]);
              walk_rsp_cacheline <= lb_data;
            end else
`endif
            begin
              state        <= RD_REQ;
              l2_req_valid <= 1'b1;
              l2_req_addr  <= {rd_addr[PA_W-1:4], 4'b0};
              l2_req_store <= 1'b0;
              l2_req_data  <= '0;
            end
          end
        end
        RD_REQ: if (l2_req_ready) begin
          l2_req_valid <= 1'b0;
          state        <= RD_WAIT;
        end
        RD_WAIT: if (l2_rsp_valid) begin
          line  <= l2_rsp_data;
          state <= RD_RSP;
        end
        RD_RSP: begin
          walk_rsp_valid     <= 1'b1;
          walk_rsp_data      <= pte_half(line, rd_addr[3]);
          walk_rsp_cacheline <= line;
          state              <= IDLE;
        end
        MK_RD_REQ: if (l2_req_ready) begin
          l2_req_valid <= 1'b0;
          state        <= MK_RD_WAIT;
        end
        MK_RD_WAIT: if (l2_rsp_valid) begin
          line  <= l2_rsp_data;
          state <= MK_MOD;
        end
        MK_MOD: begin
          if (mk_new == mk_old) begin
            state <= MK_RSP;
          end else begin
            line         <= mk_line;
            l2_req_valid <= 1'b1;
            l2_req_store <= 1'b1;
            l2_req_data  <= mk_line;
            state        <= MK_WR_REQ;
          end
        end
        MK_WR_REQ: if (l2_req_ready) begin
          l2_req_valid <= 1'b0;
          l2_req_store <= 1'b0;
          l2_req_data  <= '0;
          state        <= MK_WR_WAIT;
        end
        MK_WR_WAIT: if (l2_rsp_valid) state <= MK_RSP;
        MK_RSP: begin
          mark_rsp_valid <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (walk_req_valid) begin
        rd_pend <= 1'b1;
        rd_addr <= walk_req_addr[PA_W-1:3];
      end
      if (mark_valid) begin
        mk_pend <= 1'b1;
        mk_a    <= mark_accessed;
        mk_d    <= mark_dirty;
        mk_addr <= mark_addr[PA_W-1:3];
      end
    end
  end

  // A second request of the same kind must not arrive before the first is answered
  assert property (@(posedge clk) disable iff (reset) !(walk_req_valid && rd_pend && !rd_done));
  assert property (@(posedge clk) disable iff (reset) !(mark_valid && mk_pend && !mk_done));

endmodule

// File: tb/tb_pte_mem_responder.sv
// tb/tb_pte_mem_responder.sv - directed table-driven bench for pte_mem_responder
module tb_pte_mem_responder;

  logic         clk = 1'b0;
  logic         reset;
  logic         walk_req_valid;
  logic [31:0]  walk_req_addr;
  logic         walk_rsp_valid;
  logic [63:0]  walk_rsp_data;
  logic [127:0] walk_rsp_cacheline;
  logic         mark_valid, mark_accessed, mark_dirty;
  logic [63:0]  mark_addr;
  logic         mark_rsp_valid;
  logic         l2_req_valid, l2_req_ready;
  logic [31:0]  l2_req_addr;
  logic         l2_req_store;
  logic [127:0] l2_req_data;
  logic         l2_rsp_valid;
  logic [127:0] l2_rsp_data;

  int total = 0;
  int bad   = 0;
  int n_walk = 0;
  int n_mark = 0;

  always #5 clk = ~clk;

  pte_mem_responder #(.PA_W(32)) dut (
    .clk                (clk),
    .reset              (reset),
    .walk_req_valid     (walk_req_valid),
    .walk_req_addr      (walk_req_addr),
    .walk_rsp_valid     (walk_rsp_valid),
    .walk_rsp_data      (walk_rsp_data),
    .walk_rsp_cacheline (walk_rsp_cacheline),
    .mark_valid         (mark_valid),
    .mark_accessed      (mark_accessed),
    .mark_dirty         (mark_dirty),
    .mark_addr          (mark_addr),
    .mark_rsp_valid     (mark_rsp_valid),
    .l2_req_valid       (l2_req_valid),
    .l2_req_ready       (l2_req_ready),
    .l2_req_addr        (l2_req_addr),
    .l2_req_store       (l2_req_store),
    .l2_req_data        (l2_req_data),
    .l2_rsp_valid       (l2_rsp_valid),
    .l2_rsp_data        (l2_rsp_data)
  );

  always @(negedge clk) begin
    if (!reset) begin
      if (walk_rsp_valid) n_walk++;
      if (mark_rsp_valid) n_mark++;
    end
  end

  typedef struct {
    bit           is_mark;
    logic [63:0]  addr;
    bit           a;
    bit           d;
    logic [127:0] line;
    bit           exp_wr;
    logic [127:0] exp_out;
    logic [31:0]  l2_addr;
  } vec_t;

  vec_t vecs[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return l2_req_valid;
      1:       return walk_rsp_valid;
      default: return mark_rsp_valid;
    endcase
  endfunction

  task automatic wait_for(input string name, input int sel, input int budget);
    int c;
    c = 0;
    while (sig(sel) !== 1'b1 && c < budget) begin
      step();
      c++;
    end
    chk({name, "_seen"}, {127'b0, sig(sel)}, 128'd1);
  endtask

  task automatic serve(input string nm, input logic [31:0] addr, input logic store,
                       input logic [127:0] data, input logic [127:0] rsp);
    wait_for({nm, "_req"}, 0, 20);
    chk({nm, "_addr"},  l2_req_addr,  addr);
    chk({nm, "_store"}, l2_req_store, store);
    chk({nm, "_data"},  l2_req_data,  data);
    l2_req_ready = 1'b1;
    step();
    l2_req_ready = 1'b0;
    chk({nm, "_req_drop"}, l2_req_valid, 0);
    step();
    l2_rsp_valid = 1'b1;
    l2_rsp_data  = rsp;
    step();
    l2_rsp_valid = 1'b0;
    l2_rsp_data  = '0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string nm;
    nm = $sformatf("v%0d", idx);
    if (!v.is_mark) begin
      walk_req_valid = 1'b1;
      walk_req_addr  = v.addr[31:0];
      step();
      walk_req_valid = 1'b0;
      chk({nm, "_req_early"}, l2_req_valid, 0);
      step();
      chk({nm, "_req_lat"}, l2_req_valid, 1);
      serve({nm, "_rd"}, v.l2_addr, 1'b0, 128'h0, v.line);
      chk({nm, "_rsp_early"}, walk_rsp_valid, 0);
      step();
      chk({nm, "_rsp_lat"}, walk_rsp_valid, 1);
      chk({nm, "_rsp_data"}, walk_rsp_data, v.exp_out);
      chk({nm, "_rsp_line"}, walk_rsp_cacheline, v.line);
      step();
      chk({nm, "_rsp_once"}, walk_rsp_valid, 0);
    end else begin
      mark_valid    = 1'b1;
      mark_accessed = v.a;
      mark_dirty    = v.d;
      mark_addr     = v.addr;
      step();
      mark_valid    = 1'b0;
      mark_accessed = 1'b0;
      mark_dirty    = 1'b0;
      step();
      if (!v.a && !v.d) begin
        chk({nm, "_noflag_rsp"}, mark_rsp_valid, 1);
        chk({nm, "_noflag_l2"}, l2_req_valid, 0);
      end else begin
        chk({nm, "_req_lat"}, l2_req_valid, 1);
        serve({nm, "_rd"}, v.l2_addr, 1'b0, 128'h0, v.line);
        if (v.exp_wr) serve({nm, "_wr"}, v.l2_addr, 1'b1, v.exp_out, {4{32'hDEADBEEF}});
        wait_for({nm, "_mrsp"}, 2, 20);
        chk({nm, "_no_extra_l2"}, l2_req_valid, 0);
      end
      step();
      chk({nm, "_mrsp_once"}, mark_rsp_valid, 0);
    end
  endtask

  initial begin
    int w0, m0;
    reset          = 1'b1;
    walk_req_valid = 1'b0;
    walk_req_addr  = '0;
    mark_valid     = 1'b0;
    mark_accessed  = 1'b0;
    mark_dirty     = 1'b0;
    mark_addr      = '0;
    l2_req_ready   = 1'b0;
    l2_rsp_valid   = 1'b0;
    l2_rsp_data    = '0;

    vecs[0] = '{1'b0, 64'h1008, 1'b0, 1'b0, {64'hAAAA_0001, 64'hBBBB_0001}, 1'b0, 128'hAAAA_0001, 32'h1000};
    vecs[1] = '{1'b0, 64'h1010, 1'b0, 1'b0, {64'h1111, 64'h2222}, 1'b0, 128'h2222, 32'h1010};
    vecs[2] = '{1'b0, 64'hFFFF_FFF8, 1'b0, 1'b0, {64'hDEAD_BEEF_0000_0001, 64'h5}, 1'b0,
                128'hDEAD_BEEF_0000_0001, 32'hFFFF_FFF0};
    vecs[3] = '{1'b1, 64'h2000, 1'b1, 1'b0, {64'h0, 64'h01}, 1'b1, {64'h0, 64'h41}, 32'h2000};
    vecs[4] = '{1'b1, 64'h2008, 1'b0, 1'b1, {64'hC1, 64'h01}, 1'b0, 128'h0, 32'h2000};
    vecs[5] = '{1'b1, 64'h2008, 1'b0, 1'b1, {64'h01, 64'h05}, 1'b1, {64'hC1, 64'h05}, 32'h2000};
    vecs[6] = '{1'b1, 64'h4000, 1'b0, 1'b0, 128'h0, 1'b0, 128'h0, 32'h4000};
    vecs[7] = '{1'b1, 64'h2008, 1'b1, 1'b0, {64'h41, 64'h0}, 1'b0, 128'h0, 32'h2000};
    vecs[8] = '{1'b1, 64'hFFFF_0000_0000_2000, 1'b1, 1'b0, {64'h0, 64'h80}, 1'b1, {64'h0, 64'hC0}, 32'h2000};
    vecs[9] = '{1'b1, 64'h2000, 1'b1, 1'b1, {64'h9, 64'h0}, 1'b1, {64'h9, 64'hC0}, 32'h2000};

    step(); step(); step();
    chk("rst_l2_valid",  l2_req_valid, 0);
    chk("rst_l2_addr",   l2_req_addr, 0);
    chk("rst_walk_rsp",  walk_rsp_valid, 0);
    chk("rst_walk_data", walk_rsp_data, 0);
    chk("rst_mark_rsp",  mark_rsp_valid, 0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // same-cycle read and mark: mark's read and write go first, then the walk read
    w0 = n_walk;
    m0 = n_mark;
    walk_req_valid = 1'b1;
    walk_req_addr  = 32'h5008;
    mark_valid     = 1'b1;
    mark_accessed  = 1'b1;
    mark_addr      = 64'h6000;
    step();
    walk_req_valid = 1'b0;
    mark_valid     = 1'b0;
    mark_accessed  = 1'b0;
    serve("both_mk_rd", 32'h6000, 1'b0, 128'h0, {64'h0, 64'h01});
    serve("both_mk_wr", 32'h6000, 1'b1, {64'h0, 64'h41}, 128'h0);
    wait_for("both_mrsp", 2, 20);
    serve("both_rd", 32'h5000, 1'b0, 128'h0, {64'h77, 64'h66});
    wait_for("both_wrsp", 1, 20);
    chk("both_wdata", walk_rsp_data, 64'h77);
    step(); step(); step();
    chk("both_walk_once", n_walk - w0, 1);
    chk("both_mark_once", n_mark - m0, 1);

    // stalled write request holds its fields; then reset lands in MK_WR_WAIT
    mark_valid    = 1'b1;
    mark_accessed = 1'b1;
    mark_addr     = 64'h7000;
    step();
    mark_valid    = 1'b0;
    mark_accessed = 1'b0;
    serve("stall_rd", 32'h7000, 1'b0, 128'h0, {64'h0, 64'h03});
    wait_for("stall_wr", 0, 20);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall%0d_valid", i), l2_req_valid, 1);
      chk($sformatf("stall%0d_addr", i),  l2_req_addr, 32'h7000);
      chk($sformatf("stall%0d_store", i), l2_req_store, 1);
      chk($sformatf("stall%0d_data", i),  l2_req_data, {64'h0, 64'h43});
      step();
    end
    l2_req_ready = 1'b1;
    step();
    l2_req_ready = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("mrst_l2_valid",  l2_req_valid, 0);
    chk("mrst_l2_addr",   l2_req_addr, 0);
    chk("mrst_l2_store",  l2_req_store, 0);
    chk("mrst_l2_data",   l2_req_data, 0);
    chk("mrst_walk_rsp",  walk_rsp_valid, 0);
    chk("mrst_walk_data", walk_rsp_data, 0);
    chk("mrst_walk_line", walk_rsp_cacheline, 0);
    chk("mrst_mark_rsp",  mark_rsp_valid, 0);
    reset        = 1'b0;
    l2_rsp_valid = 1'b1;
    step();
    l2_rsp_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("stray%0d_quiet", i), {l2_req_valid, mark_rsp_valid, walk_rsp_valid}, 0);
      step();
    end

`ifdef PTE_RSP_LINEBUF_EN
    walk_req_valid = 1'b1;
    walk_req_addr  = 32'h3000;
    step();
    walk_req_valid = 1'b0;
    serve("lb_rd", 32'h3000, 1'b0, 128'h0, {64'h3111, 64'h3000});
    wait_for("lb_rsp0", 1, 20);
    chk("lb_data0", walk_rsp_data, 64'h3000);
    step();
    walk_req_valid = 1'b1;
    walk_req_addr  = 32'h3008;
    step();
    walk_req_valid = 1'b0;
    chk("lb_hit_l2_t1", l2_req_valid, 0);
    step();
    chk("lb_hit_rsp", walk_rsp_valid, 1);
    chk("lb_hit_data", walk_rsp_data, 64'h3111);
    chk("lb_hit_l2_t2", l2_req_valid, 0);
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
